encoder_reset_sequencer: RTL and testbench
==========================================

# encoder_reset_sequencer

Avalon-MM slave that generates timed, per-channel reset pulses for the quadrature encoder counters. It replaces direct software toggling of an encoder reset line with a small sequencer. Requests come from Nios software register writes and from hardware request lines such as limit switches. The block merges them and drives each selected channel's reset for a programmed pulse width, followed by a programmed holdoff. It then flags completion and, optionally, raises an interrupt.

## Interface
- NUM_CH, 4: number of encoder channels (1..8).
- CNT_W, 16: width of the pulse and holdoff counters.

- clk  in  1  system clock.
- reset_n  in  1  reset, asynchronous, active-low.
- address  in  2  register select.
- chipselect  in  1  slave select.
- write_n  in  1  active-low write strobe; a write occurs when chipselect && ~write_n.
- writedata  in  32  write data.
- readdata  out  32  combinational read mux on address; unused bits are 0.
- hw_req  in  NUM_CH  hardware reset requests, synchronous to clk, rising-edge triggered.
- enc_reset  out  NUM_CH  active-high reset to each encoder channel, registered.
- busy  out  1  high whenever state != IDLE.
- irq  out  1  equals done && irq_en.

## Operation
- Registers:
  - addr 0 CTRL: a write ORs writedata[NUM_CH-1:0] into pending. A read returns pending.
  - addr 1 PULSE: [CNT_W-1:0], reset value 16. A value of 0 is treated as 1.
  - addr 2 HOLDOFF: [CNT_W-1:0], reset value 4. A value of 0 means no holdoff.
  - addr 3 STATUS:
    - Read: bit0 busy, bit1 done, bit2 irq_en, bits[8+NUM_CH-1:8] active.
    - Write: bit1=1 clears done (W1C); bit2 writes irq_en.
- Edge detect: hw_prev resets to all-ones, so an hw_req already high at reset release does not trigger. A bit is set in pending when hw_req=1 and hw_prev=0.
- Pending set sources: a CTRL write and hw_req edges, ORed together.
- FSM states: IDLE, ASSERT, HOLD.
  - IDLE: if pending != 0:
    - active <= pending.
    - The latched pending bits are cleared.
    - cnt <= max(PULSE,1).
    - Go to ASSERT.
  - ASSERT: enc_reset = active, cnt decrements. At cnt==1:
    - If HOLDOFF != 0: cnt <= HOLDOFF, go to HOLD.
    - Otherwise: set done, clear active, go to IDLE.
  - HOLD: enc_reset = 0, cnt decrements. At cnt==1: set done, clear active, go to IDLE.
- PULSE and HOLDOFF are sampled only when loaded into cnt. Writes made while busy apply to the next sequence.
- Requests arriving while busy accumulate in pending, including requests for channels that are currently active. Each such request produces a second, separate sequence.
- Simultaneous events:
  - A pending bit set in the same cycle IDLE latches and clears it: the set wins, and the bit stays pending.
  - A done set and a W1C clear in the same cycle: the set wins.
- Reset values: enc_reset=0, busy=0, irq=0, done=0, irq_en=0, pending=0, active=0, state=IDLE.
- Asserting reset_n mid-sequence drops enc_reset on the asynchronous edge and discards all pending requests.

## Timing
- A CTRL write sampled at edge E0 makes pending visible after E0.
- The FSM enters ASSERT at edge E1 = E0+1. enc_reset and busy are high after E1.
- enc_reset is high for exactly max(PULSE,1) cycles and falls after edge E1+PULSE.
- busy falls, and done and irq rise, after edge E1+PULSE+HOLDOFF.
- A back-to-back sequence from pending re-enters ASSERT one cycle after IDLE is reached. IDLE lasts exactly 1 cycle.
- hw_req path: the edge is sampled at Eh and pending is set after Eh. Timing from that point is identical to the CTRL path.
- readdata has zero-wait-state combinational read, as in the existing PIO slaves.

## Test plan
- Reset defaults: read addr 1 → 16; addr 2 → 4; addr 3 → 0; all outputs low.
- CTRL write 0x5 with PULSE=3, HOLDOFF=2 → enc_reset=0101 for exactly 3 cycles. busy is high for 5 cycles, then done=1. irq stays 0 while irq_en=0.
- irq_en=1, PULSE=0, HOLDOFF=0 → a single-cycle enc_reset pulse, then irq=1. A STATUS write of 0x6 clears done, drops irq, and keeps irq_en=1.
- During an active sequence on ch0, pulse hw_req[2] and write CTRL=0x1 → after the first sequence completes, a second sequence runs with active=0101.
- hw_req[1] held high through reset release → no pulse. Toggle 0→1 → one pulse on ch1 only. Holding it high afterwards causes no repeat.
- Assert reset_n in the middle of the ASSERT state → enc_reset drops immediately. After release: state IDLE, pending=0, no residual pulse.

Source files
------------

// File: rtl/encoder_reset_sequencer.sv
// Avalon-MM sequencer that merges software and hardware reset requests and
// drives timed per-channel encoder reset pulses followed by a holdoff window.
module encoder_reset_sequencer #(
  parameter int NUM_CH = 4,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [1:0]        address,
  input  logic              chipselect,
  input  logic              write_n,
  input  logic [31:0]       writedata,
  output logic [31:0]       readdata,
  input  logic [NUM_CH-1:0] hw_req,
  output logic [NUM_CH-1:0] enc_reset,
  output logic              busy,
  output logic              irq
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ASSERT = 2'd1,
    HOLD   = 2'd2
  } state_e;

  localparam logic [CNT_W-1:0]  CNT_ZERO    = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0]  CNT_ONE     = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0]  PULSE_RST   = CNT_W'(16);
  localparam logic [CNT_W-1:0]  HOLDOFF_RST = CNT_W'(4);
  localparam logic [NUM_CH-1:0] CH_ZERO     = {NUM_CH{1'b0}};
  localparam logic [NUM_CH-1:0] CH_ONES     = {NUM_CH{1'b1}};

  state_e              state_q;
  logic [CNT_W-1:0]    cnt_q;
  logic [NUM_CH-1:0]   active_q;
  logic [NUM_CH-1:0]   enc_reset_q;
  logic                busy_q;
  logic                irq_q;
  logic [NUM_CH-1:0]   pending_q, pending_d;
  logic [NUM_CH-1:0]   hw_prev_q;
  logic [CNT_W-1:0]    pulse_q, pulse_d;
  logic [CNT_W-1:0]    holdoff_q, holdoff_d;
  logic                done_q, done_d;
  logic                irq_en_q, irq_en_d;

  logic                wr_s;
  logic                start_s;
  logic                last_s;
  logic                finish_s;
  logic [NUM_CH-1:0]   hw_edge_s;
  logic [CNT_W-1:0]    pulse_load_s;
  logic                unused_wdata_s;

  assign unused_wdata_s = ^writedata;

  // Request merging, register writes and sequence-boundary decode
  always_comb begin
    wr_s         = chipselect & ~write_n;
    hw_edge_s    = hw_req & ~hw_prev_q;
    start_s      = (state_q == IDLE) && (pending_q != CH_ZERO);
    last_s       = (cnt_q == CNT_ONE);
    finish_s     = ((state_q == ASSERT) && last_s && (holdoff_q == CNT_ZERO)) ||
                   ((state_q == HOLD) && last_s);
    pulse_load_s = (pulse_q == CNT_ZERO) ? CNT_ONE : pulse_q;

    // Clearing happens first so a same-cycle set survives the latch
    pending_d = start_s ? CH_ZERO : pending_q;
    pending_d = pending_d | hw_edge_s;
    if (wr_s && (address == 2'd0)) begin
      pending_d = pending_d | writedata[NUM_CH-1:0];
    end else begin
      pending_d = pending_d;
    end

    pulse_d   = pulse_q;
    holdoff_d = holdoff_q;
    done_d    = done_q;
    irq_en_d  = irq_en_q;
    if (wr_s) begin
      case (address)
        2'd1: pulse_d   = writedata[CNT_W-1:0];
        2'd2: holdoff_d = writedata[CNT_W-1:0];
        2'd3: begin
          irq_en_d = writedata[2];
          if (writedata[1]) begin
            done_d = 1'b0;
          end else begin
            done_d = done_q;
          end
        end
        default: pulse_d = pulse_q;
      endcase
    end else begin
      done_d = done_q;
    end
    if (finish_s) begin
      done_d = 1'b1;
    end else begin
      done_d = done_d;
    end
  end

  // Zero-wait-state read mux
  always_comb begin
    readdata = 32'd0;
    case (address)
      2'd0: readdata[NUM_CH-1:0] = pending_q;
      2'd1: readdata[CNT_W-1:0]  = pulse_q;
      2'd2: readdata[CNT_W-1:0]  = holdoff_q;
      2'd3: begin
        readdata[0]           = busy_q;
        readdata[1]           = done_q;
        readdata[2]           = irq_en_q;
        readdata[8 +: NUM_CH] = active_q;
      end
      default: readdata = 32'd0;
    endcase
  end

  // Register file, request latch and interrupt output
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pending_q <= CH_ZERO;
      hw_prev_q <= CH_ONES;
      pulse_q   <= PULSE_RST;
      holdoff_q <= HOLDOFF_RST;
      done_q    <= 1'b0;
      irq_en_q  <= 1'b0;
      irq_q     <= 1'b0;
    end else begin
      pending_q <= pending_d;
      hw_prev_q <= hw_req;
      pulse_q   <= pulse_d;
      holdoff_q <= holdoff_d;
      done_q    <= done_d;
      irq_en_q  <= irq_en_d;
      irq_q     <= done_d & irq_en_d;
    end
  end

  // Pulse/holdoff sequencer with registered enc_reset and busy
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      cnt_q       <= CNT_ZERO;
      active_q    <= CH_ZERO;
      enc_reset_q <= CH_ZERO;
      busy_q      <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start_s) begin
            active_q    <= pending_q;
            enc_reset_q <= pending_q;
            cnt_q       <= pulse_load_s;
            busy_q      <= 1'b1;
            state_q     <= ASSERT;
          end
        end
        ASSERT: begin
          if (last_s) begin
            enc_reset_q <= CH_ZERO;
            if (holdoff_q != CNT_ZERO) begin
              cnt_q   <= holdoff_q;
              state_q <= HOLD;
            end else begin
              active_q <= CH_ZERO;
              busy_q   <= 1'b0;
              state_q  <= IDLE;
            end
          end else begin
            cnt_q <= cnt_q - CNT_ONE;
          end
        end
        HOLD: begin
          if (last_s) begin
            active_q <= CH_ZERO;
            busy_q   <= 1'b0;
            state_q  <= IDLE;
          end else begin
            cnt_q <= cnt_q - CNT_ONE;
          end
        end
        default: begin
          enc_reset_q <= CH_ZERO;
          active_q    <= CH_ZERO;
          busy_q      <= 1'b0;
          state_q     <= IDLE;
        end
      endcase
    end
  end

  assign enc_reset = enc_reset_q;
  assign busy      = busy_q;
  assign irq       = irq_q;

endmodule

// File: tb/tb_encoder_reset_sequencer.sv
// Scoreboard bench: stimulus queues per-cycle expected outputs and read data,
// a negedge monitor pops and compares them.
module tb_encoder_reset_sequencer;

  logic        clk;
  logic        reset_n;
  logic [1:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic [3:0]  hw_req;
  logic [3:0]  enc_reset;
  logic        busy;
  logic        irq;

  encoder_reset_sequencer #(.NUM_CH(4), .CNT_W(16)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .address    (address),
    .chipselect (chipselect),
    .write_n    (write_n),
    .writedata  (writedata),
    .readdata   (readdata),
    .hw_req     (hw_req),
    .enc_reset  (enc_reset),
    .busy       (busy),
    .irq        (irq)
  );

  typedef struct {
    bit          is_rd;
    logic [31:0] rd;
    logic [3:0]  enc;
    logic        busy;
    logic        irq;
    bit [63:0]   tag;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad   = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic void push_out(input bit [63:0] tag, input logic [3:0] e,
                                   input logic b, input logic i, input int n);
    exp_t x;
    x.is_rd = 1'b0; x.rd = 32'd0; x.enc = e; x.busy = b; x.irq = i; x.tag = tag;
    for (int k = 0; k < n; k++) sb.push_back(x);
  endfunction

  always @(negedge clk) begin
    exp_t x;
    if (sb.size() > 0) begin
      x = sb.pop_front();
      total++;
      if (x.is_rd) begin
        if (readdata !== x.rd) begin
          bad++;
          $display("FAIL %0s: readdata got %h want %h", x.tag, readdata, x.rd);
        end
      end else if ({enc_reset, busy, irq} !== {x.enc, x.busy, x.irq}) begin
        bad++;
        $display("FAIL %0s: enc/busy/irq got %b/%b/%b want %b/%b/%b",
                 x.tag, enc_reset, busy, irq, x.enc, x.busy, x.irq);
      end
    end
  end

  task automatic drain();
    for (int i = 0; i < 200; i++) begin
      if (sb.size() == 0) return;
      @(posedge clk); #1;
    end
    total++;
    bad++;
    $display("FAIL drain: %0d entries left, want 0", sb.size());
    sb.delete();
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    address = a; writedata = d; chipselect = 1'b1; write_n = 1'b0;
    @(posedge clk); #1;
    chipselect = 1'b0; write_n = 1'b1;
  endtask

  task automatic rd_chk(input bit [63:0] tag, input logic [1:0] a, input logic [31:0] exp_v);
    exp_t x;
    drain();
    address = a; chipselect = 1'b1; write_n = 1'b1;
    x.is_rd = 1'b1; x.rd = exp_v; x.enc = 4'd0; x.busy = 1'b0; x.irq = 1'b0; x.tag = tag;
    sb.push_back(x);
    @(posedge clk); #1;
    chipselect = 1'b0;
    drain();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n = 1'b0; address = 2'd0; chipselect = 1'b0; write_n = 1'b1;
    writedata = 32'd0; hw_req = 4'b0010;
    #22 reset_n = 1'b1;
    @(posedge clk); #1;

    // reset defaults; hw_req[1] held high through release must not trigger
    push_out("rst_out", 4'h0, 1'b0, 1'b0, 3);
    drain();
    rd_chk("rst_puls", 2'd1, 32'd16);
    rd_chk("rst_hold", 2'd2, 32'd4);
    rd_chk("rst_stat", 2'd3, 32'd0);
    rd_chk("rst_pend", 2'd0, 32'd0);

    // CTRL 0x5, PULSE=3, HOLDOFF=2, irq disabled
    wr(2'd1, 32'd3);
    wr(2'd2, 32'd2);
    rd_chk("puls_rb", 2'd1, 32'd3);
    rd_chk("hold_rb", 2'd2, 32'd2);
    wr(2'd0, 32'h5);
    push_out("s5_idle", 4'h0, 1'b0, 1'b0, 1);
    push_out("s5_asrt", 4'h5, 1'b1, 1'b0, 3);
    push_out("s5_hold", 4'h0, 1'b1, 1'b0, 2);
    push_out("s5_done", 4'h0, 1'b0, 1'b0, 2);
    drain();
    rd_chk("s5_stat", 2'd3, 32'h2);
    rd_chk("s5_pend", 2'd0, 32'h0);

    // irq_en=1, PULSE=0 acts as 1, no holdoff
    wr(2'd3, 32'h6);
    push_out("clr_done", 4'h0, 1'b0, 1'b0, 1);
    drain();
    rd_chk("ien_stat", 2'd3, 32'h4);
    wr(2'd1, 32'd0);
    wr(2'd2, 32'd0);
    rd_chk("puls0_rb", 2'd1, 32'd0);
    wr(2'd0, 32'h8);
    push_out("p0_idle", 4'h0, 1'b0, 1'b0, 1);
    push_out("p0_asrt", 4'h8, 1'b1, 1'b0, 1);
    push_out("p0_irq", 4'h0, 1'b0, 1'b1, 2);
    drain();
    rd_chk("p0_stat", 2'd3, 32'h6);
    wr(2'd3, 32'h6);
    push_out("w1c_irq", 4'h0, 1'b0, 1'b0, 1);
    drain();
    rd_chk("w1c_stat", 2'd3, 32'h4);

    // requests during an active ch0 sequence queue a second sequence
    wr(2'd1, 32'd4);
    wr(2'd2, 32'd1);
    wr(2'd0, 32'h1);
    push_out("b1_idle", 4'h0, 1'b0, 1'b0, 1);
    push_out("b1_asrt", 4'h1, 1'b1, 1'b0, 4);
    push_out("b1_hold", 4'h0, 1'b1, 1'b0, 1);
    push_out("b_gap", 4'h0, 1'b0, 1'b1, 1);
    push_out("b2_asrt", 4'h5, 1'b1, 1'b1, 4);
    push_out("b2_hold", 4'h0, 1'b1, 1'b1, 1);
    push_out("b2_done", 4'h0, 1'b0, 1'b1, 1);
    @(posedge clk); #1;
    @(posedge clk); #1;
    hw_req[2] = 1'b1;
    @(posedge clk); #1;
    hw_req[2] = 1'b0;
    wr(2'd0, 32'h1);
    drain();
    rd_chk("b_stat", 2'd3, 32'h6);
    rd_chk("b_pend", 2'd0, 32'h0);

    // hw_req[1] rising edge gives exactly one ch1 pulse
    wr(2'd3, 32'h6);
    push_out("h_clr", 4'h0, 1'b0, 1'b0, 1);
    drain();
    hw_req[1] = 1'b0;
    @(posedge clk); #1;
    hw_req[1] = 1'b1;
    @(posedge clk); #1;
    push_out("h_idle", 4'h0, 1'b0, 1'b0, 1);
    push_out("h_asrt", 4'h2, 1'b1, 1'b0, 4);
    push_out("h_hold", 4'h0, 1'b1, 1'b0, 1);
    push_out("h_norep", 4'h0, 1'b0, 1'b1, 5);
    drain();
    rd_chk("h_stat", 2'd3, 32'h6);

    // reset asserted during ASSERT with a request pending
    wr(2'd0, 32'h3);
    push_out("r_idle", 4'h0, 1'b0, 1'b1, 1);
    @(posedge clk); #1;
    push_out("r_asrt", 4'h3, 1'b1, 1'b1, 1);
    wr(2'd0, 32'h4);
    reset_n = 1'b0;
    push_out("r_drop", 4'h0, 1'b0, 1'b0, 2);
    repeat (2) @(posedge clk);
    #3 reset_n = 1'b1;
    @(posedge clk); #1;
    push_out("r_quiet", 4'h0, 1'b0, 1'b0, 6);
    drain();
    rd_chk("r_pend", 2'd0, 32'h0);
    rd_chk("r_stat", 2'd3, 32'h0);
    rd_chk("r_puls", 2'd1, 32'd16);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
